// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_defs : shared definitions for the execute-stage multiply/divide unit.
//   - md op codes (also used by the D-stage decoder to form op/start)
//   - default busy lengths for mult and div
//   - FSM state type and the arithmetic result bundle
// ---------------------------------------------------------------------------
package md_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Result of one mult/div: HI, LO and a flag that suppresses write-back.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } md_res_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// ---------------------------------------------------------------------------
// md_arith : combinational multiply/divide datapath.
//   op  in  3   md op code
//   a   in  32  rs operand
//   b   in  32  rt operand
//   res out     {hi, lo, div0}; div0 set for div/divu with b==0
// Non mult/div ops return zero.
// ---------------------------------------------------------------------------
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_res_t     res
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               b_zero;
    logic               s_ovf;
    logic        [31:0] dvs_s;
    logic        [31:0] dvs_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_zero = (b == 32'd0);
    // 0x80000000 / -1 overflows; dividing by 1 instead yields exactly the
    // required LO=0x80000000, HI=0.
    assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // A zero divisor is replaced by 1 so the divider never sees /0; the
    // result is discarded anyway through div0.
    assign dvs_s = (b_zero || s_ovf) ? 32'd1 : b;
    assign dvs_u = b_zero ? 32'd1 : b;

    // Signed operators truncate toward zero; remainder follows dividend sign.
    assign quo_s = $signed(a) / $signed(dvs_s);
    assign rem_s = $signed(a) % $signed(dvs_s);
    assign quo_u = a / dvs_u;
    assign rem_u = a % dvs_u;

    always_comb begin
        res = '0;
        case (op)
            MD_MULT:  begin res.hi = prod_s[63:32]; res.lo = prod_s[31:0]; end
            MD_MULTU: begin res.hi = prod_u[63:32]; res.lo = prod_u[31:0]; end
            MD_DIV:   begin res.hi = rem_s; res.lo = quo_s; res.div0 = b_zero; end
            MD_DIVU:  begin res.hi = rem_u; res.lo = quo_u; res.div0 = b_zero; end
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : execute-stage multiply/divide unit owning HI/LO.
//   clk    in   1   clock, rising edge
//   reset  in   1   async active-low reset
//   start  in   1   E-stage instr is mult/multu/div/divu/mthi/mtlo
//   op     in   3   md op code (md_defs)
//   A      in   32  rs operand
//   B      in   32  rt operand
//   busy   out  1   multi-cycle operation in flight
//   HI     out  32  HI register
//   LO     out  32  LO register
// The result is computed at the accept edge and held until the counter
// expires; HI/LO keep their old values for the whole busy window.
// ---------------------------------------------------------------------------
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter holds at most MAX_CYC-1.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    md_res_t          arith_res;
    md_res_t          lat;
    logic             accept;
    logic             accept_long;
    logic             done;

    md_arith u_arith (
        .op  (op),
        .a   (A),
        .b   (B),
        .res (arith_res)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_long)        state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0)          state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs / control ----
    // The counter is loaded with N-1 at accept, so the edge that finds it at
    // zero is the N-th edge after accept: busy is high for exactly N cycles.
    // A start on that completion edge is ignored because busy is still high.
    always_comb begin
        busy        = (state == ST_RUN);
        accept      = start && (state == ST_IDLE);
        accept_long = accept && is_long_op(op);
        done        = (state == ST_RUN) && (cnt == '0);
    end

    // ---- counter and latched result ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            lat <= '0;
        end else begin
            if (accept_long) begin
                cnt <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
                lat <= arith_res;
            end else if (busy && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // ---- HI/LO architectural registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done) begin
            // Divide by zero leaves HI/LO untouched.
            if (!lat.div0) begin
                HI <= lat.hi;
                LO <= lat.lo;
            end
        end else if (accept && (op == MD_MTHI)) begin
            HI <= A;
        end else if (accept && (op == MD_MTLO)) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : directed + randomized self-checking bench for md_unit.
// A behavioural model tracks HI/LO and the remaining busy cycles; a compare
// process checks busy/HI/LO against it on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_md_unit;
    import md_defs::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] ref_md(input logic [2:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] pu;
        case (o)
            MD_MULT: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                return x * y;
            end
            MD_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu;
            end
            MD_DIV: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    logic        m_pvalid;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi     <= '0;
            m_lo     <= '0;
            m_pend   <= '0;
            m_pvalid <= 1'b0;
            m_left   <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_pvalid) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    m_pend   <= ref_md(op, A, B);
                    m_pvalid <= 1'b1;
                    m_left   <= MC;
                end
                MD_DIV, MD_DIVU: begin
                    m_pend   <= (B != 0) ? ref_md(op, A, B) : 64'd0;
                    m_pvalid <= (B != 0);
                    m_left   <= DC;
                end
                MD_MTHI: m_hi <= A;
                MD_MTLO: m_lo <= A;
                default: ;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("cyc_hi", HI, m_hi);
            chk("cyc_lo", LO, m_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    // All drivers run at posedge+2.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        cmp_en = 1'b1;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;

        // signed mult
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        chk("mult_busy_len", n, MC);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);
        chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);

        // unsigned mult
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        chk("multu_busy_len", n, MC);
        chk("multu_hi", HI, 32'd1);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        // signed div
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        chk("div_busy_len", n, DC);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("model_div_lo", m_lo, 32'hFFFF_FFFD);

        // unsigned div
        issue(MD_DIVU, 32'd7, 32'd2);
        busy_len(n);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        // signed overflow case
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        chk("div_ovf_lo", LO, 32'h8000_0000);
        chk("div_ovf_hi", HI, 32'd0);
        chk("model_ovf_lo", m_lo, 32'h8000_0000);

        // mthi/mtlo then divide by zero
        issue(MD_MTHI, 32'h11, 32'd0);
        chk("mthi_1cyc", HI, 32'h11);
        issue(MD_MTLO, 32'h22, 32'd0);
        chk("mtlo_1cyc", LO, 32'h22);
        issue(MD_DIVU, 32'd99, 32'd0);
        busy_len(n);
        chk("div0_busy_len", n, DC);
        chk("div0_hi", HI, 32'h11);
        chk("div0_lo", LO, 32'h22);

        // starts during busy and on the completion edge are ignored
        issue(MD_MULT, 32'd6, 32'd7);                   // accept edge E0
        start = 1'b1; op = MD_MTLO; A = 32'd5; B = '0;  // pulse across E2
        @(posedge clk); #2;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;                              // now E4+2
        start = 1'b1; op = MD_MTLO; A = 32'd5;
        @(posedge clk); #2;                              // E5: completion
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_lo", LO, 32'd42);
        chk("ign_hi", HI, 32'd0);
        @(posedge clk); #2;                              // re-presented mtlo accepted
        start = 1'b0;
        chk("mtlo_after", LO, 32'd5);

        // async reset in the middle of a div
        issue(MD_DIV, 32'd100, 32'd3);
        @(posedge clk); #2;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        issue(MD_MULT, 32'd3, 32'd4);
        busy_len(n);
        chk("post_rst_lo", LO, 32'd12);
        chk("post_rst_hi", HI, 32'd0);

        // randomized traffic, including undefined ops and held starts
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(posedge clk); #2;
        end
        start = 1'b0;
        busy_len(n);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
